pixel_aligner: RTL and testbench
================================

PIXEL_ALIGNER -- requirements
Module: pixel_aligner

Interface
REQ-001 SHALL have parameter PIXEL_BITS, default 9, bits per pixel; a word is 8 pixels (72 bits at default).
REQ-002 SHALL have port clk_draw  input  1  draw-domain clock; the block uses this one clock only.
REQ-003 SHALL have port rst_draw  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  window inputs valid this cycle.
REQ-005 SHALL have port unaligned_pixels  input  16*PIXEL_BITS  window p0..p15, p0 in MSBs; p0..p7 are the previous chunk, p8..p15 the current doubled chunk.
REQ-006 SHALL have port unaligned_valid_mask  input  16  per-pixel valid; bit 15 = p0.
REQ-007 SHALL have port alignment_shift  input  3  pixel offset s of the span within a word.
REQ-008 SHALL have port lb_addr  input  9  line-buffer word address of the current chunk.
REQ-009 SHALL have port span_end  input  1  qualifies in_valid: this is the last chunk of the span.
REQ-010 SHALL have port lb_wr_en  output  1  line-buffer write strobe.
REQ-011 SHALL have port lb_wr_addr  output  9  write word address.
REQ-012 SHALL have port lb_wr_data  output  8*PIXEL_BITS  word pixels w0..w7, w0 (leftmost) in MSBs.
REQ-013 SHALL have port lb_wr_mask  output  8  per-pixel write enable; bit 7 = w0.
REQ-014 SHALL have port busy  output  1  high while in FLUSH; upstream must hold in_valid low.
REQ-015 SHALL have port overrun  output  1  sticky error flag.

Function
REQ-016 SHALL implement states IDLE, ACTIVE, FLUSH.
REQ-017 SHALL, when in_valid is accepted, register one write for the next cycle: lb_wr_en=1, lb_wr_addr=lb_addr, wi = p(8-s+i), and mask bit for wi = valid bit of p(8-s+i), for i=0..7.
REQ-018 SHALL, on an accepted chunk in IDLE (first chunk of a span), force mask to 0 for every wi taken from p0..p7, so stale previous-span pixels are never written.
REQ-019 SHALL transition IDLE->ACTIVE on accepted in_valid with span_end=0, and stay in ACTIVE on further such chunks.
REQ-020 SHALL, on accepted in_valid with span_end=1 from IDLE or ACTIVE, go to FLUSH if s!=0, else to IDLE.
REQ-021 SHALL store p8..p15, their valid bits, s and lb_addr of the last accepted chunk.
REQ-022 SHALL, in FLUSH, emit one write on the cycle after the last chunk's write: addr = stored lb_addr+1 mod 512 (511 wraps to 0); wi = stored p(16-s+i) for i<s, with mask = stored valid bits; wi = 0 with mask 0 for i>=s. It SHALL then return to IDLE.
REQ-023 SHALL drive busy=1 exactly in the FLUSH state.
REQ-024 SHALL ignore in_valid asserted while busy (no write, no state change) and set overrun=1 until reset.
REQ-025 SHALL drive lb_wr_en=0, with lb_wr_addr, lb_wr_data and lb_wr_mask = 0, on every cycle with no write.
REQ-026 SHALL handle back-to-back chunks at one per cycle with no bubbles in IDLE/ACTIVE.

Reset
REQ-027 SHALL, when rst_draw=1 at a clock edge, enter IDLE and clear all outputs (lb_wr_en, lb_wr_addr, lb_wr_data, lb_wr_mask, busy, overrun) to 0.
REQ-028 SHALL, when reset is taken while in FLUSH or with a write pending, discard the pending flush or write; no write is emitted after reset.

Verification
REQ-029 SHALL verify: single chunk, s=0, lb_addr=1, p8..p15=1,1,2,2,3,3,4,4, all valid, span_end=1 -> next cycle: write at addr 1, data 1,1,2,2,3,3,4,4, mask FF; no flush; busy stays 0.
REQ-030 SHALL verify: span s=2. Chunk A at addr 10 with p8..15=1,1,2,2,3,3,4,4 -> addr 10, data 0,0,1,1,2,2,3,3 (w0,w1 masked), mask 3F. Chunk B at addr 11 with p8..15=5,5,6,6,7,7,8,8 and span_end -> addr 11, data 4,4,5,5,6,6,7,7, mask FF; then addr 12, data 8,8,0..., mask C0.
REQ-031 SHALL verify: span_end at lb_addr=511 with s=3 -> flush write at addr 0, mask E0.
REQ-032 SHALL verify: s=0 with unaligned_valid_mask=000F -> mask 0F, data unchanged.
REQ-033 SHALL verify: in_valid during FLUSH -> that chunk produces no write and overrun=1 until rst_draw.
REQ-034 SHALL verify: rst_draw asserted on the FLUSH cycle -> no flush write and all outputs 0 the next cycle.

Source files
------------

// File: rtl/pixel_aligner.sv
// Realigns a 16-pixel window into 8-pixel line-buffer words at pixel offset s,
// emitting one trailing flush word when a span ends mid-word.
module pixel_aligner #(
    parameter int PIXEL_BITS = 9
) (
    input  logic                    clk_draw,
    input  logic                    rst_draw,
    input  logic                    in_valid,
    input  logic [16*PIXEL_BITS-1:0] unaligned_pixels,
    input  logic [15:0]             unaligned_valid_mask,
    input  logic [2:0]              alignment_shift,
    input  logic [8:0]              lb_addr,
    input  logic                    span_end,
    output logic                    lb_wr_en,
    output logic [8:0]              lb_wr_addr,
    output logic [8*PIXEL_BITS-1:0] lb_wr_data,
    output logic [7:0]              lb_wr_mask,
    output logic                    busy,
    output logic                    overrun
);

    localparam int WORD_BITS = 8 * PIXEL_BITS;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        FLUSH
    } state_t;

    state_t state;
    state_t state_next;

    logic [WORD_BITS-1:0]      stored_pixels;
    logic [7:0]                stored_valid;
    logic [2:0]                stored_shift;
    logic [8:0]                stored_addr;

    logic                      accept;
    logic                      overrun_hit;
    logic [3:0]                chunk_shamt;
    logic [3:0]                flush_shamt;
    logic [16*PIXEL_BITS-1:0]  win_shifted;
    logic [15:0]               valid_shifted;
    logic [WORD_BITS-1:0]      flush_shifted;
    logic [7:0]                flush_valid;
    logic [7:0]                first_chunk_keep;

    logic                      wr_en_next;
    logic [8:0]                wr_addr_next;
    logic [WORD_BITS-1:0]      wr_data_next;
    logic [7:0]                wr_mask_next;

    assign accept      = in_valid && (state != FLUSH);
    assign overrun_hit = in_valid && (state == FLUSH);
    assign busy        = (state == FLUSH);

    // Shifting the window left by (8-s) pixels puts p(8-s+i) at word slot i.
    always_comb begin
        chunk_shamt      = 4'd8 - {1'b0, alignment_shift};
        flush_shamt      = 4'd8 - {1'b0, stored_shift};
        win_shifted      = unaligned_pixels << (int'(chunk_shamt) * PIXEL_BITS);
        valid_shifted    = unaligned_valid_mask << chunk_shamt;
        flush_shifted    = stored_pixels << (int'(flush_shamt) * PIXEL_BITS);
        flush_valid      = stored_valid << flush_shamt;
        first_chunk_keep = 8'hFF >> alignment_shift;
    end

    always_ff @(posedge clk_draw) begin
        if (rst_draw) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        wr_en_next   = 1'b0;
        wr_addr_next = '0;
        wr_data_next = '0;
        wr_mask_next = '0;
        case (state)
            IDLE, ACTIVE: begin
                if (accept) begin
                    wr_en_next   = 1'b1;
                    wr_addr_next = lb_addr;
                    wr_data_next = win_shifted[16*PIXEL_BITS-1 -: WORD_BITS];
                    // On the first chunk of a span, slots fed from p0..p7 hold stale pixels.
                    wr_mask_next = valid_shifted[15:8]
                                   & ((state == IDLE) ? first_chunk_keep : 8'hFF);
                    if (!span_end) begin
                        state_next = ACTIVE;
                    end else if (alignment_shift != 3'd0) begin
                        state_next = FLUSH;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            FLUSH: begin
                wr_en_next   = 1'b1;
                wr_addr_next = stored_addr + 9'd1;
                wr_data_next = flush_shifted;
                wr_mask_next = flush_valid;
                state_next   = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_draw) begin
        if (rst_draw) begin
            stored_pixels <= '0;
            stored_valid  <= '0;
            stored_shift  <= '0;
            stored_addr   <= '0;
        end else if (accept) begin
            stored_pixels <= unaligned_pixels[WORD_BITS-1:0];
            stored_valid  <= unaligned_valid_mask[7:0];
            stored_shift  <= alignment_shift;
            stored_addr   <= lb_addr;
        end
    end

    // Write port is fully registered and held at zero whenever no write is issued.
    always_ff @(posedge clk_draw) begin
        if (rst_draw) begin
            lb_wr_en   <= 1'b0;
            lb_wr_addr <= '0;
            lb_wr_data <= '0;
            lb_wr_mask <= '0;
            overrun    <= 1'b0;
        end else begin
            lb_wr_en   <= wr_en_next;
            lb_wr_addr <= wr_addr_next;
            lb_wr_data <= wr_data_next;
            lb_wr_mask <= wr_mask_next;
            overrun    <= overrun | overrun_hit;
        end
    end

endmodule

// File: tb/tb_pixel_aligner.sv
// Directed bench for pixel_aligner: hand-computed write words, masks, flush and
// overrun behaviour, checked with immediate assertions.
module tb_pixel_aligner;

    localparam int PB = 9;

    logic            clk_draw;
    logic            rst_draw;
    logic            in_valid;
    logic [16*PB-1:0] unaligned_pixels;
    logic [15:0]     unaligned_valid_mask;
    logic [2:0]      alignment_shift;
    logic [8:0]      lb_addr;
    logic            span_end;
    logic            lb_wr_en;
    logic [8:0]      lb_wr_addr;
    logic [8*PB-1:0] lb_wr_data;
    logic [7:0]      lb_wr_mask;
    logic            busy;
    logic            overrun;

    int checks   = 0;
    int failures = 0;

    pixel_aligner #(.PIXEL_BITS(PB)) dut (
        .clk_draw             (clk_draw),
        .rst_draw             (rst_draw),
        .in_valid             (in_valid),
        .unaligned_pixels     (unaligned_pixels),
        .unaligned_valid_mask (unaligned_valid_mask),
        .alignment_shift      (alignment_shift),
        .lb_addr              (lb_addr),
        .span_end             (span_end),
        .lb_wr_en             (lb_wr_en),
        .lb_wr_addr           (lb_wr_addr),
        .lb_wr_data           (lb_wr_data),
        .lb_wr_mask           (lb_wr_mask),
        .busy                 (busy),
        .overrun              (overrun)
    );

    initial clk_draw = 1'b0;
    always #5 clk_draw = ~clk_draw;

    function automatic logic [8*PB-1:0] pack8(input int a, input int b, input int c, input int d,
                                              input int e, input int f, input int g, input int h);
        return {9'(a), 9'(b), 9'(c), 9'(d), 9'(e), 9'(f), 9'(g), 9'(h)};
    endfunction

    task automatic step();
        @(posedge clk_draw);
        #1;
    endtask

    task automatic apply_stimulus(input logic v, input logic [8*PB-1:0] prev, input logic [8*PB-1:0] cur,
                                  input logic [15:0] vmask, input logic [2:0] s,
                                  input logic [8:0] addr, input logic last);
        in_valid             = v;
        unaligned_pixels     = {prev, cur};
        unaligned_valid_mask = vmask;
        alignment_shift      = s;
        lb_addr              = addr;
        span_end             = last;
    endtask

    task automatic idle_inputs();
        apply_stimulus(1'b0, '0, '0, 16'h0000, 3'd0, 9'd0, 1'b0);
    endtask

    task automatic check_output(input string tag, input logic e_en, input logic [8:0] e_addr,
                                input logic [8*PB-1:0] e_data, input logic [7:0] e_mask,
                                input logic e_busy, input logic e_ovr);
        checks++;
        assert (lb_wr_en === e_en) else begin
            failures++;
            $display("[TB] FAIL %s.en observed=%b expected=%b", tag, lb_wr_en, e_en);
            $error("[TB] %s.en", tag);
        end
        checks++;
        assert (lb_wr_addr === e_addr) else begin
            failures++;
            $display("[TB] FAIL %s.addr observed=%0d expected=%0d", tag, lb_wr_addr, e_addr);
            $error("[TB] %s.addr", tag);
        end
        checks++;
        assert (lb_wr_data === e_data) else begin
            failures++;
            $display("[TB] FAIL %s.data observed=%h expected=%h", tag, lb_wr_data, e_data);
            $error("[TB] %s.data", tag);
        end
        checks++;
        assert (lb_wr_mask === e_mask) else begin
            failures++;
            $display("[TB] FAIL %s.mask observed=%h expected=%h", tag, lb_wr_mask, e_mask);
            $error("[TB] %s.mask", tag);
        end
        checks++;
        assert (busy === e_busy) else begin
            failures++;
            $display("[TB] FAIL %s.busy observed=%b expected=%b", tag, busy, e_busy);
            $error("[TB] %s.busy", tag);
        end
        checks++;
        assert (overrun === e_ovr) else begin
            failures++;
            $display("[TB] FAIL %s.overrun observed=%b expected=%b", tag, overrun, e_ovr);
            $error("[TB] %s.overrun", tag);
        end
    endtask

    initial begin
        rst_draw = 1'b1;
        idle_inputs();
        step();
        step();
        check_output("reset", 1'b0, 9'd0, '0, 8'h00, 1'b0, 1'b0);
        rst_draw = 1'b0;
        step();
        check_output("idle_after_reset", 1'b0, 9'd0, '0, 8'h00, 1'b0, 1'b0);

        // Single aligned chunk: no flush expected.
        apply_stimulus(1'b1, '0, pack8(1,1,2,2,3,3,4,4), 16'hFFFF, 3'd0, 9'd1, 1'b1);
        step();
        idle_inputs();
        check_output("single_s0", 1'b1, 9'd1, pack8(1,1,2,2,3,3,4,4), 8'hFF, 1'b0, 1'b0);
        step();
        check_output("single_s0_noflush", 1'b0, 9'd0, '0, 8'h00, 1'b0, 1'b0);

        // Partial valid mask with s=0: mask passes straight through.
        apply_stimulus(1'b1, '0, pack8(9,8,7,6,5,4,3,2), 16'h000F, 3'd0, 9'd5, 1'b1);
        step();
        idle_inputs();
        check_output("mask_000F", 1'b1, 9'd5, pack8(9,8,7,6,5,4,3,2), 8'h0F, 1'b0, 1'b0);
        step();
        check_output("mask_000F_after", 1'b0, 9'd0, '0, 8'h00, 1'b0, 1'b0);

        // Two-chunk span with s=2, back to back, followed by a flush word.
        apply_stimulus(1'b1, '0, pack8(1,1,2,2,3,3,4,4), 16'hFFFF, 3'd2, 9'd10, 1'b0);
        step();
        apply_stimulus(1'b1, pack8(1,1,2,2,3,3,4,4), pack8(5,5,6,6,7,7,8,8), 16'hFFFF, 3'd2, 9'd11, 1'b1);
        check_output("span_chunkA", 1'b1, 9'd10, pack8(0,0,1,1,2,2,3,3), 8'h3F, 1'b0, 1'b0);
        step();
        idle_inputs();
        check_output("span_chunkB", 1'b1, 9'd11, pack8(4,4,5,5,6,6,7,7), 8'hFF, 1'b1, 1'b0);
        step();
        check_output("span_flush", 1'b1, 9'd12, pack8(8,8,0,0,0,0,0,0), 8'hC0, 1'b0, 1'b0);
        step();
        check_output("span_after", 1'b0, 9'd0, '0, 8'h00, 1'b0, 1'b0);

        // Address wrap on flush: 511 + 1 -> 0.
        apply_stimulus(1'b1, '0, pack8(1,2,3,4,5,6,7,8), 16'hFFFF, 3'd3, 9'd511, 1'b1);
        step();
        idle_inputs();
        check_output("wrap_chunk", 1'b1, 9'd511, pack8(0,0,0,1,2,3,4,5), 8'h1F, 1'b1, 1'b0);
        step();
        check_output("wrap_flush", 1'b1, 9'd0, pack8(6,7,8,0,0,0,0,0), 8'hE0, 1'b0, 1'b0);
        step();

        // in_valid during FLUSH is dropped and latches overrun.
        apply_stimulus(1'b1, '0, pack8(1,2,3,4,5,6,7,8), 16'hFFFF, 3'd1, 9'd20, 1'b1);
        step();
        apply_stimulus(1'b1, '0, pack8(9,9,9,9,9,9,9,9), 16'hFFFF, 3'd0, 9'd30, 1'b1);
        check_output("ovr_chunk", 1'b1, 9'd20, pack8(0,1,2,3,4,5,6,7), 8'h7F, 1'b1, 1'b0);
        step();
        idle_inputs();
        check_output("ovr_flush", 1'b1, 9'd21, pack8(8,0,0,0,0,0,0,0), 8'h80, 1'b0, 1'b1);
        step();
        check_output("ovr_dropped", 1'b0, 9'd0, '0, 8'h00, 1'b0, 1'b1);
        step();
        check_output("ovr_sticky", 1'b0, 9'd0, '0, 8'h00, 1'b0, 1'b1);

        rst_draw = 1'b1;
        step();
        rst_draw = 1'b0;
        check_output("ovr_cleared", 1'b0, 9'd0, '0, 8'h00, 1'b0, 1'b0);

        // Reset on the FLUSH cycle discards the flush write.
        apply_stimulus(1'b1, '0, pack8(1,2,3,4,5,6,7,8), 16'hFFFF, 3'd4, 9'd40, 1'b1);
        step();
        idle_inputs();
        check_output("rstflush_chunk", 1'b1, 9'd40, pack8(0,0,0,0,1,2,3,4), 8'h0F, 1'b1, 1'b0);
        rst_draw = 1'b1;
        step();
        rst_draw = 1'b0;
        check_output("rstflush_reset", 1'b0, 9'd0, '0, 8'h00, 1'b0, 1'b0);
        step();
        check_output("rstflush_after", 1'b0, 9'd0, '0, 8'h00, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
